// File: rtl/stimgen_pkg.sv
// Shared constants, enums and LFSR tap table for the RV32I random instruction source.
package stimgen_pkg;

  localparam logic [6:0]  OPC_OP    = 7'h33;
  localparam logic [6:0]  OPC_OPIMM = 7'h13;
  localparam logic [6:0]  OPC_LOAD  = 7'h03;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    ModeRtype = 2'd0,
    ModeItype = 2'd1,
    ModeLoad  = 2'd2,
    ModeMixed = 2'd3
  } stim_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } stim_state_e;

  // Galois masks for a right-shifting LFSR; bit (tap-1) set for each polynomial tap.
  // Returns zero for widths that have no entry.
  function automatic logic [63:0] lfsr_taps(int unsigned width);
    logic [63:0] mask;
    case (width)
      32'd40:  mask = 64'h0000_00A0_0014_0000;
      32'd48:  mask = 64'h0000_C000_0018_0000;
      32'd56:  mask = 64'h00C0_0006_0000_0000;
      32'd64:  mask = 64'hD800_0000_0000_0000;
      default: mask = 64'h0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rv32_instr_stimgen_if.sv
// Valid/ready instruction stream from the stimulus generator to the imem response path.
interface rv32_instr_stimgen_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (output out_valid, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_instr, output out_ready);
endinterface

// File: rtl/stimgen_lfsr.sv
// Galois LFSR with synchronous load and step enable; next_o is the state after one step.
module stimgen_lfsr
  import stimgen_pkg::*;
#(
  parameter int unsigned      Width    = 64,
  parameter logic [Width-1:0] ResetVal = Width'(856)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] seed_i,
  output logic [Width-1:0] next_o
);

  localparam logic [63:0]      TapsFull = lfsr_taps(Width);
  localparam logic [Width-1:0] Taps     = TapsFull[Width-1:0];

  if (Width > 64 || TapsFull == 64'h0) begin : g_taps_chk
    $error("stimgen_lfsr: no tap mask for this Width");
  end

  logic [Width-1:0] state_q, state_d, step;

  always_comb begin
    step    = state_q[0] ? ((state_q >> 1) ^ Taps) : (state_q >> 1);
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (en_i) begin
      state_d = step;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ResetVal;
    end else begin
      state_q <= state_d;
    end
  end

  assign next_o = step;

endmodule

// File: rtl/rv32_instr_stimgen.sv
// Random RV32I (R-type / I-type ALU / load) instruction source with run-length control.
// Optional STIM_HAZARD_EN forces rs1 to the previous rd on 1/8 of instructions.
module rv32_instr_stimgen
  import stimgen_pkg::*;
#(
  parameter int unsigned       LFSR_W       = 64,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(64'd856),
  parameter int unsigned       CNT_W        = 16,
  parameter int unsigned       XLEN         = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [LFSR_W-1:0]    seed,
  input  logic [CNT_W-1:0]     num_instr,
  rv32_instr_stimgen_if.master out_if,
  output logic                 busy,
  output logic                 done
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("rv32_instr_stimgen: XLEN must be 32");
  end
  if (LFSR_W < 40) begin : g_width_chk
    $error("rv32_instr_stimgen: LFSR_W must be at least 40");
  end
  if (DEFAULT_SEED == '0) begin : g_seed_chk
    $error("rv32_instr_stimgen: DEFAULT_SEED must be nonzero");
  end

  function automatic logic [31:0] encode(stim_mode_e m, logic [32:0] f);
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    stim_mode_e  eff;
    logic [31:0] w;
    rd  = f[4:0];
    rs1 = f[9:5];
    rs2 = f[14:10];
    f3  = f[17:15];
    imm = f[29:18];
    f7  = 7'h00;
    eff = m;
    if (m == ModeMixed) begin
      eff = (f[31:30] == 2'd0) ? ModeRtype : (f[31:30] == 2'd1) ? ModeItype : ModeLoad;
    end
    case (eff)
      ModeRtype: begin
        // Only ADD/SUB and SRL/SRA have a legal funct7=0x20 variant.
        if (f[32] && (f3 == 3'd0 || f3 == 3'd5)) f7 = 7'h20;
        w = {f7, rs2, rs1, f3, rd, OPC_OP};
      end
      ModeItype: begin
        if (f3 == 3'd1) begin
          imm &= 12'h01F;
        end else if (f3 == 3'd5) begin
          imm &= 12'h41F;
        end
        w = {imm, rs1, f3, rd, OPC_OPIMM};
      end
      default: w = {imm, rs1, f3 & 3'b100, rd, OPC_LOAD};
    endcase
    return w;
  endfunction

  stim_state_e       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              bounded_q, bounded_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [LFSR_W-1:0] seed_eff, lfsr_next, gen_src;
  logic [32:0]       gen_f;
  logic              lfsr_load, lfsr_en, fire;

  assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;
  assign fire     = valid_q & out_if.out_ready;

`ifdef STIM_HAZARD_EN
  localparam int unsigned UsedBits = 36;
  logic [4:0] prev_rd_q, prev_rd_d;
`else
  localparam int unsigned UsedBits = 33;
`endif

  logic unused_gen_bits;
  assign unused_gen_bits = ^gen_src[LFSR_W-1:UsedBits];

  stimgen_lfsr #(
    .Width   (LFSR_W),
    .ResetVal(DEFAULT_SEED)
  ) u_lfsr (
    .clk_i (clk),
    .rst_ni(reset_n),
    .load_i(lfsr_load),
    .en_i  (lfsr_en),
    .seed_i(seed_eff),
    .next_o(lfsr_next)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bounded_d = bounded_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    done_d    = done_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    // A new word comes from the seed on start, otherwise from the stepped LFSR.
    gen_src   = (state_q == StRun) ? lfsr_next : seed_eff;
    gen_f     = gen_src[32:0];
`ifdef STIM_HAZARD_EN
    prev_rd_d = prev_rd_q;
    if (state_q != StRun && start) begin
      prev_rd_d = 5'd0;
    end else if (fire) begin
      prev_rd_d = instr_q[11:7];
    end
    if (gen_src[35:33] == 3'b000) gen_f[9:5] = prev_rd_d;
`endif

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lfsr_load = 1'b1;
          count_d   = num_instr;
          bounded_d = |num_instr;
          done_d    = 1'b0;
          valid_d   = 1'b1;
          instr_d   = encode(stim_mode_e'(mode), gen_f);
          state_d   = StRun;
        end
      end
      StRun: begin
        if (fire) begin
          lfsr_en = 1'b1;
          if (bounded_q && count_q == CNT_W'(1)) begin
            state_d = StDone;
            count_d = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            instr_d = NOP;
          end else begin
            if (bounded_q) count_d = count_q - CNT_W'(1);
            instr_d = encode(stim_mode_e'(mode), gen_f);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      bounded_q <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef STIM_HAZARD_EN
      prev_rd_q <= 5'd0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bounded_q <= bounded_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef STIM_HAZARD_EN
      prev_rd_q <= prev_rd_d;
`endif
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_instr = instr_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_rv32_instr_stimgen.sv
// Directed bench for rv32_instr_stimgen: per-cycle model compare plus literal stream checks.
module tb_rv32_instr_stimgen;

  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam logic [63:0] SEED_D = 64'd856;
  localparam logic [63:0] MASK64 = 64'hD800_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [63:0] seed = 64'd0;
  logic [15:0] num_instr = 16'd0;
  logic        busy, done;

  rv32_instr_stimgen_if stim_if ();

  rv32_instr_stimgen #(
    .LFSR_W      (64),
    .DEFAULT_SEED(64'd856),
    .CNT_W       (16),
    .XLEN        (32)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .mode     (mode),
    .seed     (seed),
    .num_instr(num_instr),
    .out_if   (stim_if),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // First four words of seed 856 in RTYPE mode, worked out by hand.
  logic [31:0] exp_rt [4] = '{32'h000D0C33, 32'h00068633, 32'h00030B33, 32'h000185B3};
  logic [31:0] got_q[$];
  logic [31:0] first_q[$];

  function automatic logic [63:0] m_step(input logic [63:0] s);
    if ((s % 64'd2) == 64'd1) return (s / 64'd2) ^ MASK64;
    return s / 64'd2;
  endfunction

  function automatic logic [31:0] m_enc(input logic [63:0] s, input logic [1:0] md);
    int unsigned rd, rs1, rs2, f3, imm, cls, f7b, f7, kind, w;
    rd   = 32'(s % 64'd32);
    rs1  = 32'((s >> 5) % 64'd32);
    rs2  = 32'((s >> 10) % 64'd32);
    f3   = 32'((s >> 15) % 64'd8);
    imm  = 32'((s >> 18) % 64'd4096);
    cls  = 32'((s >> 30) % 64'd4);
    f7b  = 32'((s >> 32) % 64'd2);
    kind = 32'(md);
    if (kind == 3) kind = (cls == 0) ? 0 : (cls == 1) ? 1 : 2;
    if (kind == 0) begin
      f7 = (f7b == 1 && (f3 == 0 || f3 == 5)) ? 32 : 0;
      w  = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 51;
    end else if (kind == 1) begin
      if (f3 == 1) imm = imm % 32;
      else if (f3 == 5) imm = (imm % 32) + ((imm / 1024) % 2) * 1024;
      w = (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 19;
    end else begin
      f3 = (f3 >= 4) ? 4 : 0;
      w  = (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 3;
    end
    return w;
  endfunction

  function automatic logic [63:0] m_seed(input logic [63:0] s);
    return (s == 64'd0) ? SEED_D : s;
  endfunction

  // Transaction-level model: what the stream must look like after each edge.
  logic        m_valid = 1'b0, m_done = 1'b0, m_unb = 1'b0;
  logic [31:0] m_instr = NOP_W;
  logic [63:0] m_lfsr  = SEED_D;
  int unsigned m_left  = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_instr <= NOP_W;
      m_lfsr  <= SEED_D;
      m_left  <= 0;
    end else if (!m_valid && start) begin
      m_lfsr  <= m_seed(seed);
      m_instr <= m_enc(m_seed(seed), mode);
      m_left  <= 32'(num_instr);
      m_unb   <= (num_instr == 16'd0);
      m_valid <= 1'b1;
      m_done  <= 1'b0;
    end else if (m_valid && stim_if.out_ready) begin
      m_lfsr <= m_step(m_lfsr);
      if (!m_unb && m_left == 1) begin
        m_valid <= 1'b0;
        m_done  <= 1'b1;
        m_instr <= NOP_W;
      end else begin
        m_left  <= m_left - 1;
        m_instr <= m_enc(m_step(m_lfsr), mode);
      end
    end
  end

  task automatic legal(input logic [31:0] w);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       ok;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    ok  = 1'b1;
    case (opc)
      7'h33: if ((f3 != 3'd0 && f3 != 3'd5) ? (f7 != 7'h00) : (f7 != 7'h00 && f7 != 7'h20)) ok = 1'b0;
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
      end
      7'h03: if (f3 != 3'd0 && f3 != 3'd4) ok = 1'b0;
      default: ok = 1'b0;
    endcase
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL legal_fields t=%0t instr=%h not a legal generated encoding", $time, w);
    end
  endtask

  logic        stalled = 1'b0;
  logic [31:0] held = 32'h0;

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (stim_if.out_valid !== m_valid || stim_if.out_instr !== m_instr ||
          busy !== m_valid || done !== m_done) begin
        errors++;
        $display("FAIL model t=%0t valid=%b want %b instr=%h want %h busy=%b want %b done=%b want %b",
                 $time, stim_if.out_valid, m_valid, stim_if.out_instr, m_instr, busy, m_valid,
                 done, m_done);
      end
      if (stalled && stim_if.out_valid) begin
        checks++;
        if (stim_if.out_instr !== held) begin
          errors++;
          $display("FAIL stall_stable t=%0t instr=%h want %h", $time, stim_if.out_instr, held);
        end
      end
      if (stim_if.out_valid) legal(stim_if.out_instr);
      if (stim_if.out_valid && stim_if.out_ready) got_q.push_back(stim_if.out_instr);
      stalled = stim_if.out_valid && !stim_if.out_ready;
      held    = stim_if.out_instr;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [1:0] md, input logic [63:0] sd, input int n,
                     input int stall_lo, input int stall_hi, input int restart_at,
                     input int budget);
    got_q.delete();
    mode      = md;
    seed      = sd;
    num_instr = 16'(n);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= budget && !done; c++) begin
      stim_if.out_ready = !(c >= stall_lo && c <= stall_hi);
      start = (c == restart_at);
      if (c == restart_at) seed = ~sd;
      tick();
    end
    start = 1'b0;
    stim_if.out_ready = 1'b1;
    chk("run_done", 32'(done), 32'd1);
    chk("run_valid_low", 32'(stim_if.out_valid), 32'd0);
    chk("run_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic chk_rt_prefix(input string name);
    for (int i = 0; i < 4; i++) chk(name, got_at(i), exp_rt[i]);
  endtask

  initial begin
    stim_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_valid", 32'(stim_if.out_valid), 32'd0);
      chk("idle_instr", stim_if.out_instr, NOP_W);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      tick();
    end

    run(2'd0, 64'd856, 4, 0, -1, -1, 20);
    chk_rt_prefix("rtype_stream");

    run(2'd0, 64'd856, 4, 2, 4, -1, 20);
    chk_rt_prefix("stalled_stream");

    run(2'd1, 64'h0123_4567_89AB_CDEF, 200, 50, 52, 100, 260);
    run(2'd2, 64'h0000_0000_CAFE_F00D, 100, 10, 11, -1, 130);

    run(2'd3, 64'd856, 20, 0, -1, -1, 40);
    first_q = got_q;
    run(2'd3, 64'd856, 20, 0, -1, -1, 40);
    for (int i = 0; i < 20; i++) begin
      chk("determinism", got_at(i), (i < first_q.size()) ? first_q[i] : 32'h0);
    end

    // Unbounded run from seed 0 must follow the default seed, then reset mid-stream.
    got_q.delete();
    mode      = 2'd0;
    seed      = 64'd0;
    num_instr = 16'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 30 && got_q.size() < 6; c++) tick();
    chk("unbounded_count", 32'(got_q.size() >= 6), 32'd1);
    chk("unbounded_busy", 32'(busy), 32'd1);
    chk_rt_prefix("seed0_stream");
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(stim_if.out_valid), 32'd0);
    chk("async_rst_instr", stim_if.out_instr, NOP_W);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    run(2'd0, 64'd856, 4, 0, -1, -1, 20);
    chk_rt_prefix("replay_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
